// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared constants for the OPC5 serial receiver: FSM encoding,
//               register offsets and STATUS field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam logic [2:0] S_WAIT_HIGH = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;

    localparam logic REG_STATUS = 1'b0;
    localparam logic REG_RXDATA = 1'b1;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_OVERRUN   = 1;
    localparam int STAT_FRAMING   = 2;
    localparam int STAT_FULL      = 3;
    localparam int STAT_COUNT_LSB = 8;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_8.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_8
// Description : Byte-wide synchronous FIFO, depth 2**FIFO_AW, head exposed
//               combinationally on rdata.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_8 #(
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);

    localparam int c_depth = 2 ** FIFO_AW;

    logic [7:0]         r_mem_q [c_depth];
    logic [FIFO_AW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [FIFO_AW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [FIFO_AW:0]   r_count_q,  w_count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty = (r_count_q == '0);
    assign full  = (r_count_q == (FIFO_AW+1)'(c_depth));

    // A pop frees the slot the same clock, so a full FIFO still accepts a push
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_push) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        if (w_do_push && !w_do_pop) begin
            w_count_d = r_count_q + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            w_count_d = r_count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_q[r_wr_ptr_q] <= wdata;
        end
    end

    assign rdata = r_mem_q[r_rd_ptr_q];
    assign count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Memory-mapped 8N1 serial receiver with byte FIFO, STATUS and
//               RXDATA registers on a shared tristate 16-bit bus.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 278,
    parameter int FIFO_AW      = 3
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [15:0] data,
    input  logic        a0,
    input  logic        rnw,
    input  logic        cs_b,
    input  logic        rxd
);

    import uart_rx_pkg::*;

    localparam int              c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]          r_sync_q,     w_sync_d;
    logic [1:0]          r_arm_q,      w_arm_d;
    logic [2:0]          r_state_q,    w_state_d;
    logic [c_cnt_w-1:0]  r_cnt_q,      w_cnt_d;
    logic [2:0]          r_bit_q,      w_bit_d;
    logic [7:0]          r_shift_q,    w_shift_d;
    logic                r_overrun_q,  w_overrun_d;
    logic                r_framing_q,  w_framing_d;
    logic                r_rd_pend_q,  w_rd_pend_d;

    logic                w_rxs;
    logic                w_expired;
    logic                w_push;
    logic                w_frame_err;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [7:0]          w_head;
    logic [FIFO_AW:0]    w_count;
    logic                w_rd_sel;
    logic                w_wr_status;
    logic [15:0]         w_status;
    logic [15:0]         w_rd_word;
    logic                w_unused_data;

    assign w_rxs     = r_sync_q[1];
    assign w_expired = (r_cnt_q == '0);
    assign w_sync_d  = {r_sync_q[0], rxd};
    // The synchroniser comes out of reset forced high; hold off trusting rxs
    // until real pin samples have flushed through, so a held-low line after
    // reset keeps the receiver parked in WAIT_HIGH.
    assign w_arm_d   = {r_arm_q[0], 1'b1};

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_bit_d     = r_bit_q;
        w_shift_d   = r_shift_q;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        case (r_state_q)
            S_WAIT_HIGH: begin
                if (r_arm_q[1] && w_rxs) begin
                    w_state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!w_rxs) begin
                    w_cnt_d   = c_cnt_half;
                    w_state_d = S_START;
                end
            end
            S_START: begin
                if (!w_expired) begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end else if (!w_rxs) begin
                    w_cnt_d   = c_cnt_full;
                    w_bit_d   = 3'd0;
                    w_state_d = S_DATA;
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!w_expired) begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end else begin
                    w_shift_d = {w_rxs, r_shift_q[7:1]};
                    w_cnt_d   = c_cnt_full;
                    w_bit_d   = r_bit_q + 3'd1;
                    if (r_bit_q == 3'd7) begin
                        w_state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (!w_expired) begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end else if (w_rxs) begin
                    w_push    = 1'b1;
                    w_state_d = S_IDLE;
                end else begin
                    w_frame_err = 1'b1;
                    w_state_d   = S_WAIT_HIGH;
                end
            end
            default: begin
                w_state_d = S_WAIT_HIGH;
            end
        endcase
    end

    sync_fifo_8 #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (r_shift_q),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_rd_sel    = !cs_b && rnw;
    assign w_wr_status = !cs_b && !rnw && (a0 == REG_STATUS);
    assign w_pop       = cs_b && r_rd_pend_q;

    always_comb begin
        w_overrun_d = r_overrun_q;
        w_framing_d = r_framing_q;
        if (w_wr_status && data[STAT_OVERRUN]) begin
            w_overrun_d = 1'b0;
        end
        if (w_wr_status && data[STAT_FRAMING]) begin
            w_framing_d = 1'b0;
        end
        if (w_push && w_full && !w_pop) begin
            w_overrun_d = 1'b1;
        end
        if (w_frame_err) begin
            w_framing_d = 1'b1;
        end
    end

    // Pop is deferred to the end of the access so a multi-cycle read sees one head
    always_comb begin
        w_rd_pend_d = r_rd_pend_q;
        if (w_rd_sel && (a0 == REG_RXDATA)) begin
            w_rd_pend_d = 1'b1;
        end else if (w_pop) begin
            w_rd_pend_d = 1'b0;
        end
    end

    always_comb begin
        w_status                                = '0;
        w_status[STAT_NOT_EMPTY]                = !w_empty;
        w_status[STAT_OVERRUN]                  = r_overrun_q;
        w_status[STAT_FRAMING]                  = r_framing_q;
        w_status[STAT_FULL]                     = w_full;
        w_status[STAT_COUNT_LSB +: FIFO_AW + 1] = w_count;
    end

    assign w_rd_word = (a0 == REG_RXDATA) ? (w_empty ? 16'h0000 : {8'h00, w_head})
                                          : w_status;

    assign data          = w_rd_sel ? w_rd_word : 16'hzzzz;
    assign w_unused_data = ^{data[15:3], data[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_q    <= 2'b11;
            r_arm_q     <= 2'b00;
            r_state_q   <= S_WAIT_HIGH;
            r_cnt_q     <= '0;
            r_bit_q     <= '0;
            r_shift_q   <= '0;
            r_overrun_q <= 1'b0;
            r_framing_q <= 1'b0;
            r_rd_pend_q <= 1'b0;
        end else begin
            r_sync_q    <= w_sync_d;
            r_arm_q     <= w_arm_d;
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_bit_q     <= w_bit_d;
            r_shift_q   <= w_shift_d;
            r_overrun_q <= w_overrun_d;
            r_framing_q <= w_framing_d;
            r_rd_pend_q <= w_rd_pend_d;
        end
    end

endmodule
`default_nettype wire
